// File: rtl/inst_loader.sv
// -----------------------------------------------------------------------------
// inst_loader
//   Loads a program image from a byte stream into instruction memory while
//   holding the CPU fetch/decode path in reset.
//
//   Stream format (all multi-byte fields MSB first):
//     LEN_HI, LEN_LO  : 16-bit word count N (1 .. 2^ADDR_W)
//     4*N bytes       : instruction words
//     1 byte          : XOR of all instruction bytes
//
// Ports
//   clk         in   single clock, rising edge
//   rst         in   synchronous active-high reset
//   start       in   one-cycle request to begin a load (IDLE/DONE/ERR only)
//   byte_valid  in   byte_data holds a valid stream byte
//   byte_data   in   [7:0] stream byte
//   byte_ready  out  loader accepts a byte this cycle
//   mem_we      out  one-cycle instruction-memory write strobe
//   mem_addr    out  [ADDR_W-1:0] word address of the write
//   mem_wdata   out  [31:0] instruction word of the write
//   cpu_hold    out  keeps the PC in reset while 1
//   done        out  last load completed with a matching checksum
//   error       out  last load failed (bad length or bad checksum)
// -----------------------------------------------------------------------------
module inst_loader #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              error
);

  typedef enum logic [2:0] {
    IDLE,
    LEN_HI,
    LEN_LO,
    DATA,
    CHECK,
    DONE,
    ERR
  } state_t;

  // Largest accepted word count; 17 bits so ADDR_W=16 still fits.
  localparam logic [16:0] MAX_WORDS = 17'd1 << ADDR_W;

  state_t              state;
  logic [ADDR_W-1:0]   word_idx;
  logic [15:0]         words_left;
  logic [1:0]          byte_cnt;
  logic [7:0]          csum;
  logic [7:0]          len_hi;
  logic [23:0]         asm_word;
  logic                xfer;
  logic [15:0]         len_word;
  logic                len_bad;

  assign byte_ready = (state == LEN_HI) || (state == LEN_LO) ||
                      (state == DATA)   || (state == CHECK);
  assign xfer       = byte_valid && byte_ready;
  assign len_word   = {len_hi, byte_data};
  assign len_bad    = (len_word == 16'd0) || ({1'b0, len_word} > MAX_WORDS);

  // Payload holding registers: only meaningful after being loaded by the
  // stream, so they carry no reset.
  always_ff @(posedge clk) begin
    if (state == LEN_HI && xfer) begin
      len_hi <= byte_data;
    end
    if (state == DATA && xfer) begin
      asm_word <= {asm_word[15:0], byte_data};
    end
  end

  // Control FSM. The write strobe is registered on the 4th-byte transfer, so
  // it appears the following cycle and a reset on that same edge cancels it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      cpu_hold   <= 1'b1;
      done       <= 1'b0;
      error      <= 1'b0;
      word_idx   <= '0;
      words_left <= '0;
      byte_cnt   <= '0;
      csum       <= '0;
    end else begin
      mem_we <= 1'b0;
      case (state)
        IDLE, DONE, ERR: begin
          if (start) begin
            state      <= LEN_HI;
            done       <= 1'b0;
            error      <= 1'b0;
            cpu_hold   <= 1'b1;
            word_idx   <= '0;
            words_left <= '0;
            byte_cnt   <= '0;
            csum       <= '0;
          end
        end
        LEN_HI: begin
          if (xfer) begin
            state <= LEN_LO;
          end
        end
        LEN_LO: begin
          if (xfer) begin
            if (len_bad) begin
              state <= ERR;
              error <= 1'b1;
            end else begin
              state      <= DATA;
              words_left <= len_word;
            end
          end
        end
        DATA: begin
          if (xfer) begin
            csum     <= csum ^ byte_data;
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              mem_we     <= 1'b1;
              mem_addr   <= word_idx;
              mem_wdata  <= {asm_word, byte_data};
              word_idx   <= word_idx + 1'b1;
              words_left <= words_left - 16'd1;
              if (words_left == 16'd1) begin
                state <= CHECK;
              end
            end
          end
        end
        CHECK: begin
          if (xfer) begin
            if (byte_data == csum) begin
              state    <= DONE;
              done     <= 1'b1;
              cpu_hold <= 1'b0;
            end else begin
              state    <= ERR;
              error    <= 1'b1;
              cpu_hold <= 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inst_loader.sv
// -----------------------------------------------------------------------------
// tb_inst_loader
//   Directed bench for inst_loader (ADDR_W=8). Expected memory writes are
//   queued when a stream is issued and retired by a write monitor.
// -----------------------------------------------------------------------------
module tb_inst_loader;

  localparam int ADDR_W = 8;

  logic              clk;
  logic              rst;
  logic              start;
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              cpu_hold;
  logic              done;
  logic              error;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  wr_t sb[$];
  int  vectors;
  int  miscompares;

  logic [7:0] good_stream [11];
  logic [7:0] bad_stream  [11];

  inst_loader #(.ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .cpu_hold   (cpu_hold),
    .done       (done),
    .error      (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Write monitor: every strobe must match the head of the scoreboard.
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_we", {24'd0, mem_addr}, 32'hFFFF_FFFF);
      end else begin
        wr_t e;
        e = sb.pop_front();
        check("wr_addr", {24'd0, mem_addr}, {24'd0, e.addr});
        check("wr_data", mem_wdata, e.data);
      end
    end
  end

  // All tasks start and end 1 time unit after a rising edge.
  task automatic do_reset();
    rst = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("start_done_clr", {31'd0, done}, 32'd0);
    check("start_err_clr", {31'd0, error}, 32'd0);
    check("start_hold", {31'd0, cpu_hold}, 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    bit got;
    got = 1'b0;
    if (gaps) begin
      repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
    end
    byte_valid = 1'b1;
    byte_data  = b;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (byte_ready === 1'b1) got = 1'b1;
      @(posedge clk); #1;
    end
    byte_valid = 1'b0;
    check("byte_accept", {31'd0, got}, 32'd1);
  endtask

  task automatic check_reset_vals();
    @(negedge clk);
    check("rst_ready", {31'd0, byte_ready}, 32'd0);
    check("rst_we", {31'd0, mem_we}, 32'd0);
    check("rst_addr", {24'd0, mem_addr}, 32'd0);
    check("rst_wdata", mem_wdata, 32'd0);
    check("rst_hold", {31'd0, cpu_hold}, 32'd1);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_error", {31'd0, error}, 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic expect_result(input logic d, input logic e, input logic h);
    @(negedge clk);
    check("res_done", {31'd0, done}, {31'd0, d});
    check("res_error", {31'd0, error}, {31'd0, e});
    check("res_hold", {31'd0, cpu_hold}, {31'd0, h});
    check("res_ready", {31'd0, byte_ready}, 32'd0);
    check("sb_empty", sb.size(), 32'd0);
    @(posedge clk); #1;
    // Result must stay stable while idle.
    repeat (3) begin @(posedge clk); #1; end
    @(negedge clk);
    check("hold_done", {31'd0, done}, {31'd0, d});
    check("hold_error", {31'd0, error}, {31'd0, e});
    check("hold_cpu", {31'd0, cpu_hold}, {31'd0, h});
    @(posedge clk); #1;
  endtask

  task automatic push_good_writes();
    sb.push_back('{addr: 8'd0, data: 32'h2008_0005});
    sb.push_back('{addr: 8'd1, data: 32'h2009_000C});
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    start       = 1'b0;
    byte_valid  = 1'b0;
    byte_data   = 8'h00;
    good_stream = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05,
                    8'h20, 8'h09, 8'h00, 8'h0C, 8'h08};
    bad_stream  = good_stream;
    bad_stream[10] = 8'h09;

    // Reset state, and bytes offered in IDLE are not taken.
    do_reset();
    check_reset_vals();
    byte_valid = 1'b1;
    byte_data  = 8'hA5;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("idle_ready", {31'd0, byte_ready}, 32'd0);
      @(posedge clk); #1;
    end
    byte_valid = 1'b0;

    // Good load.
    push_good_writes();
    do_start();
    for (int i = 0; i < 11; i++) send_byte(good_stream[i], 1'b0);
    expect_result(1'b0 ^ 1'b1, 1'b0, 1'b0);

    // Bad checksum: writes still happen, then error.
    push_good_writes();
    do_start();
    for (int i = 0; i < 11; i++) send_byte(bad_stream[i], 1'b0);
    expect_result(1'b0, 1'b1, 1'b1);

    // Zero length.
    do_start();
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
    expect_result(1'b0, 1'b1, 1'b1);

    // Length 257 exceeds 256-word memory.
    do_start();
    send_byte(8'h01, 1'b0);
    send_byte(8'h01, 1'b0);
    expect_result(1'b0, 1'b1, 1'b1);

    // Length 256 is the largest legal count: loader stays in DATA.
    do_start();
    send_byte(8'h01, 1'b0);
    send_byte(8'h00, 1'b0);
    @(negedge clk);
    check("max_len_ready", {31'd0, byte_ready}, 32'd1);
    check("max_len_error", {31'd0, error}, 32'd0);
    @(posedge clk); #1;
    do_reset();
    check_reset_vals();

    // Good load with random valid gaps.
    push_good_writes();
    do_start();
    for (int i = 0; i < 11; i++) send_byte(good_stream[i], 1'b1);
    expect_result(1'b1, 1'b0, 1'b0);

    // Reset mid-load, coinciding with the 4th data byte: no write may issue.
    do_start();
    for (int i = 0; i < 5; i++) send_byte(good_stream[i], 1'b0);
    byte_valid = 1'b1;
    byte_data  = good_stream[5];
    rst        = 1'b1;
    @(posedge clk); #1;
    rst        = 1'b0;
    byte_valid = 1'b0;
    check_reset_vals();
    repeat (3) begin @(posedge clk); #1; end
    check("mid_rst_sb", sb.size(), 32'd0);

    // Fresh load after the aborted one.
    push_good_writes();
    do_start();
    for (int i = 0; i < 11; i++) send_byte(good_stream[i], 1'b0);
    expect_result(1'b1, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/inst_loader.md
INST_LOADER -- requirements
Module: inst_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, the word-address width of the instruction memory (2^ADDR_W words).
REQ-002 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port start  input  1  one-cycle request to begin a load.
REQ-005 SHALL have port byte_valid  input  1  byte_data holds a valid stream byte.
REQ-006 SHALL have port byte_data  input  8  stream byte.
REQ-007 SHALL have port byte_ready  output  1  loader accepts a byte this cycle.
REQ-008 SHALL have port mem_we  output  1  instruction-memory write strobe.
REQ-009 SHALL have port mem_addr  output  ADDR_W  instruction-memory word address.
REQ-010 SHALL have port mem_wdata  output  32  instruction word to write.
REQ-011 SHALL have port cpu_hold  output  1  holds the fetch/decode path (PC) in reset while 1.
REQ-012 SHALL have port done  output  1  last load completed with a correct checksum.
REQ-013 SHALL have port error  output  1  last load failed (bad length or bad checksum).

Function
REQ-014 SHALL accept a byte only in a cycle where byte_valid=1 and byte_ready=1 (transfer); byte_valid without byte_ready has no effect.
REQ-015 SHALL parse the stream as: LEN_HI, LEN_LO (16-bit word count N, MSB first), then 4*N instruction bytes (each word MSB first), then one checksum byte.
REQ-016 SHALL implement states IDLE, LEN_HI, LEN_LO, DATA, CHECK, DONE, ERR.
REQ-017 SHALL drive byte_ready=1 exactly in LEN_HI, LEN_LO, DATA, CHECK; 0 in IDLE, DONE, ERR.
REQ-018 SHALL move IDLE/DONE/ERR -> LEN_HI on start=1, clearing done, error, word index, byte counter and checksum, and setting cpu_hold=1 in the same edge.
REQ-019 SHALL ignore start while in LEN_HI, LEN_LO, DATA or CHECK.
REQ-020 SHALL, on the LEN_LO transfer, go to ERR if N=0 or N>2^ADDR_W, else to DATA.
REQ-021 SHALL in DATA shift each transferred byte into a 32-bit assembly register and XOR it into an 8-bit running checksum; a 2-bit byte counter wraps 3->0.
REQ-022 SHALL, on the cycle after the 4th byte of a word is transferred, assert mem_we=1 for exactly one cycle with mem_addr=word index (starting at 0) and mem_wdata=assembled word; mem_addr and mem_wdata SHALL hold their values otherwise.
REQ-023 SHALL increment the word index after each write and move DATA -> CHECK when the Nth word's 4th byte is transferred; transfers may continue on the cycle mem_we is high without corrupting the pending write.
REQ-024 SHALL, on the CHECK transfer, go to DONE (done=1, cpu_hold=0) if the byte equals the running checksum, else to ERR (error=1, cpu_hold=1).
REQ-025 SHALL keep done, error, cpu_hold stable in DONE and ERR until start or rst.
REQ-026 SHALL never assert done and error simultaneously.

Reset
REQ-027 SHALL on rst=1 (at any state, including mid-load) enter IDLE with byte_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_hold=1, done=0, error=0, counters and checksum cleared; rst has priority over start and transfers.
REQ-028 SHALL issue no mem_we in the cycle following a reset, even if a word was pending.

Verification
REQ-029 SHALL be verified: reset asserted -> all outputs at REQ-027 values, byte_valid=1 in IDLE -> byte_ready stays 0, nothing consumed.
REQ-030 SHALL be verified: start, bytes 00 02 20 08 00 05 20 09 00 0C 08 -> writes (0,0x20080005),(1,0x2009000C), each one cycle; done=1, cpu_hold=0, error=0.
REQ-031 SHALL be verified: same stream with checksum 09 -> both writes occur, then error=1, done=0, cpu_hold=1.
REQ-032 SHALL be verified: start, bytes 00 00 -> ERR after LEN_LO, no mem_we; bytes 01 01 with ADDR_W=8 -> ERR.
REQ-033 SHALL be verified: REQ-030 stream with random byte_valid gaps -> identical writes and result.
REQ-034 SHALL be verified: rst after 5 bytes of REQ-030 stream -> IDLE, no write; a fresh start and full stream then succeeds as REQ-030.
